// File: rtl/conv_pool_result_mem_if.sv
// Store / pool-control / read bus of the per-channel conv result memory.
interface conv_pool_result_mem_if #(
    parameter int CH_W   = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [ADDR_W-1:0] wr_addr;
    logic [ACC_W-1:0]  wr_data;
    logic [DATA_W-1:0] wr_bias;
    logic              pool_start;
    logic              relu_en;
    logic              busy;
    logic              pool_done;
    logic              wr_err;
    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_en, wr_ch, wr_addr, wr_data, wr_bias, pool_start, relu_en, rd_en, rd_ch, rd_addr,
        input  busy, pool_done, wr_err, rd_data, rd_valid
    );
    modport slave (
        input  wr_en, wr_ch, wr_addr, wr_data, wr_bias, pool_start, relu_en, rd_en, rd_ch, rd_addr,
        output busy, pool_done, wr_err, rd_data, rd_valid
    );
endinterface

// File: rtl/conv_pool_result_mem.sv
// Per-channel conv result banks: biased/saturated stores, in-place 2x2 max-pool (+ReLU),
// and a registered read port.
module conv_pool_result_bank #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_we,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              run_ld,
    input  logic              run_cmp,
    input  logic              pl_we,
    input  logic              relu,
    input  logic [ADDR_W-1:0] pl_addr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0]        mem [2**ADDR_W];
    logic signed [DATA_W-1:0] cur, run_q, win_max, pool_val;

    assign cur      = rdata;
    // strict compare so a tie keeps the element read first
    assign win_max  = (cur > run_q) ? cur : run_q;
    assign pool_val = (relu && win_max[DATA_W-1]) ? '0 : win_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         run_q <= '0;
        else if (run_ld)  run_q <= cur;
        else if (run_cmp) run_q <= win_max;
    end

    always_ff @(posedge clk) begin
        if (pl_we)      mem[pl_addr] <= pool_val;
        else if (st_we) mem[st_addr] <= st_data;
        if (re)         rdata <= mem[raddr];
    end
endmodule

module conv_pool_result_mem #(
    parameter int NUM_CH = 16,
    parameter int CH_W   = 4,
    parameter int MAP_W  = 14,
    parameter int MAP_H  = 14,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input logic                   clk,
    input logic                   rst,
    conv_pool_result_mem_if.slave bus
);
    localparam int PW    = MAP_W / 2;
    localparam int PH    = MAP_H / 2;
    localparam int NELEM = MAP_W * MAP_H;
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(DATA_W-1)));

    typedef enum logic [2:0] {IDLE, R0, R1, R2, R3, WR} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] pr_q, pc_q, win_a, win_k, rd_off, bank_raddr;
    logic              idle, start_ok, last_win, st_ok, rd_ok;
    logic              bank_re, run_ld, run_cmp, pl_we;
    logic              relu_q, pool_done_q, wr_err_q, rd_valid_q;
    logic [CH_W-1:0]   rd_ch_q;
    logic [DATA_W-1:0] rd_hold_q, rd_sel, st_data;
    logic signed [ACC_W:0]          sum;
    logic [NUM_CH-1:0]              st_we;
    logic [NUM_CH-1:0][DATA_W-1:0]  bank_rdata;

    assign idle     = (state_q == IDLE);
    assign start_ok = idle && bus.pool_start;
    assign last_win = (pc_q == ADDR_W'(PW-1)) && (pr_q == ADDR_W'(PH-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rd_off  = '0;
        unique case (state_q)
            IDLE: if (bus.pool_start) state_d = R0;
            R0:   state_d = R1;
            R1:   begin state_d = R2; rd_off = ADDR_W'(1);       end
            R2:   begin state_d = R3; rd_off = ADDR_W'(MAP_W);   end
            R3:   begin state_d = WR; rd_off = ADDR_W'(MAP_W+1); end
            WR:   state_d = last_win ? IDLE : R0;
            default: state_d = IDLE;
        endcase
    end

    // window origin is never below its output index, so pooling in place is safe
    assign win_a = pr_q * ADDR_W'(2*MAP_W) + (pc_q << 1);
    assign win_k = pr_q * ADDR_W'(PW) + pc_q;

    // bias add one bit wider than the accumulator so it cannot wrap before saturation
    assign sum = $signed({bus.wr_data[ACC_W-1], bus.wr_data})
               + $signed({{(ACC_W+1-DATA_W){bus.wr_bias[DATA_W-1]}}, bus.wr_bias});

    always_comb begin
        if (sum > SAT_MAX)      st_data = {1'b0, {(DATA_W-1){1'b1}}};
        else if (sum < SAT_MIN) st_data = {1'b1, {(DATA_W-1){1'b0}}};
        else                    st_data = sum[DATA_W-1:0];
    end

    assign st_ok = idle && bus.wr_en
                && ({1'b0, bus.wr_addr} < (ADDR_W+1)'(NELEM))
                && ({1'b0, bus.wr_ch}   < (CH_W+1)'(NUM_CH));
    assign rd_ok = idle && bus.rd_en;

    always_comb begin
        st_we = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (bus.wr_ch == CH_W'(i)) st_we[i] = st_ok;
    end

    assign bank_re    = rd_ok || (state_q inside {R0, R1, R2, R3});
    assign bank_raddr = idle ? bus.rd_addr : (win_a + rd_off);
    assign run_ld     = (state_q == R1);
    assign run_cmp    = (state_q == R2) || (state_q == R3);
    assign pl_we      = (state_q == WR);

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_bank
            conv_pool_result_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank (
                .clk     (clk),
                .rst     (rst),
                .st_we   (st_we[g]),
                .st_addr (bus.wr_addr),
                .st_data (st_data),
                .re      (bank_re),
                .raddr   (bank_raddr),
                .run_ld  (run_ld),
                .run_cmp (run_cmp),
                .pl_we   (pl_we),
                .relu    (relu_q),
                .pl_addr (win_k),
                .rdata   (bank_rdata[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pr_q        <= '0;
            pc_q        <= '0;
            relu_q      <= 1'b0;
            pool_done_q <= 1'b0;
            wr_err_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_ch_q     <= '0;
            rd_hold_q   <= '0;
        end else begin
            pool_done_q <= pl_we && last_win;
            if (start_ok) begin
                pr_q   <= '0;
                pc_q   <= '0;
                relu_q <= bus.relu_en;
            end else if (pl_we && !last_win) begin
                if (pc_q == ADDR_W'(PW-1)) begin
                    pc_q <= '0;
                    pr_q <= pr_q + 1'b1;
                end else begin
                    pc_q <= pc_q + 1'b1;
                end
            end
            if (start_ok)                wr_err_q <= 1'b0;
            else if (!idle && bus.wr_en) wr_err_q <= 1'b1;
            rd_valid_q <= rd_ok;
            if (rd_ok)      rd_ch_q   <= bus.rd_ch;
            if (rd_valid_q) rd_hold_q <= rd_sel;
        end
    end

    // out-of-range channels read as zero
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (rd_ch_q == CH_W'(i)) rd_sel = bank_rdata[i];
    end

    assign bus.busy      = !idle;
    assign bus.pool_done = pool_done_q;
    assign bus.wr_err    = wr_err_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_valid_q ? rd_sel : rd_hold_q;
endmodule

// File: tb/tb_conv_pool_result_mem.sv
// Drives a 4x4/2-channel and a default 14x14/16-channel instance with shared stimulus
// and compares both against an array-based reference model.
module tb_conv_pool_result_mem;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        wr_en = 0, pool_start = 0, relu_en = 0, rd_en = 0;
    logic [3:0]  wr_ch = '0, rd_ch = '0;
    logic [7:0]  wr_addr = '0, rd_addr = '0, wr_bias = '0;
    logic [19:0] wr_data = '0;

    conv_pool_result_mem_if #(.CH_W(4), .ADDR_W(8), .DATA_W(8), .ACC_W(20)) b4 (), b14 ();

    assign b4.wr_en = wr_en;           assign b14.wr_en = wr_en;
    assign b4.wr_ch = wr_ch;           assign b14.wr_ch = wr_ch;
    assign b4.wr_addr = wr_addr;       assign b14.wr_addr = wr_addr;
    assign b4.wr_data = wr_data;       assign b14.wr_data = wr_data;
    assign b4.wr_bias = wr_bias;       assign b14.wr_bias = wr_bias;
    assign b4.pool_start = pool_start; assign b14.pool_start = pool_start;
    assign b4.relu_en = relu_en;       assign b14.relu_en = relu_en;
    assign b4.rd_en = rd_en;           assign b14.rd_en = rd_en;
    assign b4.rd_ch = rd_ch;           assign b14.rd_ch = rd_ch;
    assign b4.rd_addr = rd_addr;       assign b14.rd_addr = rd_addr;

    conv_pool_result_mem #(.NUM_CH(2), .CH_W(4), .MAP_W(4), .MAP_H(4), .ADDR_W(8), .DATA_W(8), .ACC_W(20))
        dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    conv_pool_result_mem #(.NUM_CH(16), .CH_W(4), .MAP_W(14), .MAP_H(14), .ADDR_W(8), .DATA_W(8), .ACC_W(20))
        dut14 (.clk(clk), .rst(rst), .bus(b14.slave));

    int mw  [2] = '{4, 14};
    int nch [2] = '{2, 16};
    logic [7:0] m [2][16][256];
    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sat(input int s);
        if (s > 127)  return 8'h7f;
        if (s < -128) return 8'h80;
        return 8'(s);
    endfunction

    function automatic int rnd_data();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 1048575)) - 524288;
        return int'($urandom_range(0, 400)) - 200;
    endfunction

    function automatic int rnd_bias();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    function automatic void model_store(input int ch, input int addr, input int data, input int bias);
        for (int d = 0; d < 2; d++)
            if (ch < nch[d] && addr < mw[d] * mw[d]) m[d][ch][addr] = sat(data + bias);
    endfunction

    // max of each 2x2 window taken from a snapshot of the map, written to row-major index
    function automatic void model_pool(input bit relu);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < nch[d]; c++) begin
                logic [7:0] src [256];
                int w, a, mx, v;
                w = mw[d];
                for (int i = 0; i < 256; i++) src[i] = m[d][c][i];
                for (int pr = 0; pr < w / 2; pr++)
                    for (int pc = 0; pc < w / 2; pc++) begin
                        a  = 2 * pr * w + 2 * pc;
                        mx = $signed(src[a]);
                        v = $signed(src[a + 1]);     if (v > mx) mx = v;
                        v = $signed(src[a + w]);     if (v > mx) mx = v;
                        v = $signed(src[a + w + 1]); if (v > mx) mx = v;
                        if (relu && mx < 0) mx = 0;
                        m[d][c][pr * (w / 2) + pc] = 8'(mx);
                    end
            end
        end
    endfunction

    // leaves wr_en asserted so back-to-back stores take one cycle each
    task automatic store(input int ch, input int addr, input int data, input int bias);
        @(negedge clk);
        wr_en = 1; wr_ch = 4'(ch); wr_addr = 8'(addr); wr_data = 20'(data); wr_bias = 8'(bias);
        model_store(ch, addr, data, bias);
    endtask

    task automatic rd(input int ch, input int addr);
        @(negedge clk);
        rd_en = 1; rd_ch = 4'(ch); rd_addr = 8'(addr);
        @(negedge clk);
        rd_en = 0;
    endtask

    task automatic read_chk(input int ch, input int addr);
        logic [7:0] got;
        rd(ch, addr);
        chk("rd_valid4", 32'(b4.rd_valid), 32'd1);
        chk("rd_valid14", 32'(b14.rd_valid), 32'd1);
        for (int d = 0; d < 2; d++) begin
            got = (d == 0) ? b4.rd_data : b14.rd_data;
            if (ch >= nch[d])
                chk($sformatf("rd_oor_ch%0d c%0d", mw[d], ch), 32'(got), 32'h0);
            else if (addr < mw[d] * mw[d])
                chk($sformatf("rd%0d c%0d a%0d", mw[d], ch, addr), 32'(got), 32'(m[d][ch][addr]));
        end
    endtask

    task automatic fill();
        for (int c = 0; c < 16; c++)
            for (int a = 0; a < 196; a++) store(c, a, rnd_data(), rnd_bias());
        @(negedge clk) wr_en = 0;
    endtask

    task automatic full_check();
        for (int c = 0; c < 16; c++)
            for (int a = 0; a < 196; a++) read_chk(c, a);
    endtask

    // mode 0: normal, 1: hazards during the pool, 2: reset at pool cycle 7
    task automatic run_pool(input bit relu, input int mode);
        int b4c = 0, b14c = 0, d4 = 0, d14 = 0, lb4 = -1, lb14 = -1, fd4 = -1, fd14 = -1;
        int sc, sa, sd, sb;
        sc = int'($urandom_range(2, 15)); sa = int'($urandom_range(0, 195));
        sd = rnd_data(); sb = rnd_bias();
        @(negedge clk);
        pool_start = 1; relu_en = relu;
        wr_en = 1; wr_ch = 4'(sc); wr_addr = 8'(sa); wr_data = 20'(sd); wr_bias = 8'(sb);
        model_store(sc, sa, sd, sb);
        if (mode != 2) model_pool(relu);
        for (int i = 1; i <= 260; i++) begin
            @(negedge clk);
            if (b4.busy)       begin b4c++;  lb4 = i;  end
            if (b14.busy)      begin b14c++; lb14 = i; end
            if (b4.pool_done)  begin d4++;  if (fd4 < 0)  fd4 = i;  end
            if (b14.pool_done) begin d14++; if (fd14 < 0) fd14 = i; end
            if (i == 1) begin
                pool_start = 0; wr_en = 0;
                chk("wr_err_clr4", 32'(b4.wr_err), 32'd0);
                chk("wr_err_clr14", 32'(b14.wr_err), 32'd0);
            end
            if (mode == 1) begin
                if (i == 3) begin
                    wr_en = 1; wr_ch = 0; wr_addr = 0; wr_data = 20'd100; wr_bias = 0;
                end
                if (i == 4) begin
                    wr_en = 0;
                    chk("wr_err4", 32'(b4.wr_err), 32'd1);
                    chk("wr_err14", 32'(b14.wr_err), 32'd1);
                end
                if (i == 5) begin rd_en = 1; rd_ch = 0; rd_addr = 0; end
                if (i == 6) begin
                    rd_en = 0;
                    chk("rd_busy4", 32'(b4.rd_valid), 32'd0);
                    chk("rd_busy14", 32'(b14.rd_valid), 32'd0);
                end
                if (i == 8) pool_start = 1;
                if (i == 9) pool_start = 0;
            end
            if (mode == 2) begin
                if (i == 7) begin
                    rst = 0;
                    #1;
                    chk("rst_busy4", 32'(b4.busy), 32'd0);
                    chk("rst_busy14", 32'(b14.busy), 32'd0);
                    chk("rst_rd_data14", 32'(b14.rd_data), 32'd0);
                end
                if (i == 9) rst = 1;
            end
        end
        if (mode == 2) begin
            chk("rst_busy_cyc4", b4c, 7);
            chk("rst_busy_cyc14", b14c, 7);
            chk("rst_no_done4", d4, 0);
            chk("rst_no_done14", d14, 0);
        end else begin
            chk("busy_cyc4", b4c, 20);
            chk("busy_cyc14", b14c, 245);
            chk("done_cnt4", d4, 1);
            chk("done_cnt14", d14, 1);
            chk("done_at4", fd4, lb4 + 1);
            chk("done_at14", fd14, lb14 + 1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy4", 32'(b4.busy), 0);           chk("rst_busy14", 32'(b14.busy), 0);
        chk("rst_done4", 32'(b4.pool_done), 0);      chk("rst_done14", 32'(b14.pool_done), 0);
        chk("rst_werr4", 32'(b4.wr_err), 0);         chk("rst_werr14", 32'(b14.wr_err), 0);
        chk("rst_rvalid4", 32'(b4.rd_valid), 0);     chk("rst_rvalid14", 32'(b14.rd_valid), 0);
        chk("rst_rdata4", 32'(b4.rd_data), 0);       chk("rst_rdata14", 32'(b14.rd_data), 0);
        rst = 1;

        // saturation corners
        store(0, 0, 200, 10);
        store(0, 1, -300, -5);
        store(0, 2, -7, 3);
        @(negedge clk) wr_en = 0;
        rd(0, 0); chk("sat_hi4", 32'(b4.rd_data), 32'h7f); chk("sat_hi14", 32'(b14.rd_data), 32'h7f);
        rd(0, 1); chk("sat_lo4", 32'(b4.rd_data), 32'h80); chk("sat_lo14", 32'(b14.rd_data), 32'h80);
        rd(0, 2); chk("sat_mid4", 32'(b4.rd_data), 32'hfc); chk("sat_mid14", 32'(b14.rd_data), 32'hfc);
        @(negedge clk);
        chk("hold_valid14", 32'(b14.rd_valid), 0);
        chk("hold_data14", 32'(b14.rd_data), 32'hfc);
        rd(5, 0);
        chk("oor_ch_valid4", 32'(b4.rd_valid), 1);
        chk("oor_ch_data4", 32'(b4.rd_data), 0);

        fill();
        for (int a = 0; a < 16; a++) store(0, a, a, 0);
        for (int a = 0; a < 16; a++) store(1, a, -3, 0);
        @(negedge clk) wr_en = 0;

        run_pool(0, 0);
        rd(0, 0); chk("pool4_a0", 32'(b4.rd_data), 32'd5);
        rd(0, 1); chk("pool4_a1", 32'(b4.rd_data), 32'd7);
        rd(0, 2); chk("pool4_a2", 32'(b4.rd_data), 32'd13);
        rd(0, 3); chk("pool4_a3", 32'(b4.rd_data), 32'd15);
        for (int a = 0; a < 4; a++) begin
            rd(1, a); chk("tie_norelu4", 32'(b4.rd_data), 32'hfd);
        end
        full_check();

        run_pool(1, 1);
        for (int a = 0; a < 4; a++) begin
            rd(1, a); chk("relu4", 32'(b4.rd_data), 32'h00);
        end
        full_check();

        run_pool(0, 0);
        full_check();

        run_pool(0, 2);
        fill();
        run_pool(0, 0);
        full_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
